// File: rtl/binary_feature_extractor.sv
// Streaming binary-image feature extractor: per-frame foreground count, bounding box and
// centroid sums, snapshotted on frame_done. Optional macro FEAT_CENTROID_EN enables sum_x/sum_y.
module binary_feature_extractor #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        binary_pixel,
  input  logic        binary_valid,
  input  logic        frame_done,
  output logic        feat_valid,
  output logic [9:0]  fg_count,
  output logic [4:0]  bbox_xmin,
  output logic [4:0]  bbox_xmax,
  output logic [4:0]  bbox_ymin,
  output logic [4:0]  bbox_ymax,
  output logic        bbox_empty,
  output logic [14:0] sum_x,
  output logic [14:0] sum_y,
  output logic        frame_err
);

  localparam logic [9:0] NumPix  = 10'(IMG_W * IMG_H);
  localparam logic [4:0] XLast   = 5'(IMG_W - 1);
  localparam logic [4:0] MinInit = 5'd31;

  typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

  state_e     state_q, state_d;

  logic       accept;
  logic [4:0] x_q, x_d, x_upd;
  logic [4:0] y_q, y_d, y_upd;
  logic [9:0] cnt_q, cnt_d, cnt_upd;
  logic       ovf_q, ovf_d, ovf_upd;
  logic [9:0] fg_q, fg_d, fg_upd;
  logic [4:0] xmin_q, xmin_d, xmin_upd;
  logic [4:0] xmax_q, xmax_d, xmax_upd;
  logic [4:0] ymin_q, ymin_d, ymin_upd;
  logic [4:0] ymax_q, ymax_d, ymax_upd;

  logic [9:0] fg_count_q, fg_count_d;
  logic [4:0] bbox_xmin_q, bbox_xmin_d;
  logic [4:0] bbox_xmax_q, bbox_xmax_d;
  logic [4:0] bbox_ymin_q, bbox_ymin_d;
  logic [4:0] bbox_ymax_q, bbox_ymax_d;
  logic       bbox_empty_q, bbox_empty_d;
  logic       frame_err_q, frame_err_d;

  // Working values including the pixel of this cycle, so a pixel coincident with
  // frame_done lands in the snapshot.
  always_comb begin
    accept   = binary_valid && (cnt_q != NumPix);
    x_upd    = x_q;
    y_upd    = y_q;
    cnt_upd  = cnt_q;
    ovf_upd  = ovf_q | (binary_valid & ~accept);
    fg_upd   = fg_q;
    xmin_upd = xmin_q;
    xmax_upd = xmax_q;
    ymin_upd = ymin_q;
    ymax_upd = ymax_q;
    if (accept) begin
      cnt_upd = cnt_q + 10'd1;
      if (x_q == XLast) begin
        x_upd = '0;
        y_upd = y_q + 5'd1;
      end else begin
        x_upd = x_q + 5'd1;
      end
      if (binary_pixel) begin
        fg_upd = fg_q + 10'd1;
        if (x_q < xmin_q) xmin_upd = x_q;
        if (x_q > xmax_q) xmax_upd = x_q;
        if (y_q < ymin_q) ymin_upd = y_q;
        if (y_q > ymax_q) ymax_upd = y_q;
      end
    end
  end

  always_comb begin
    x_d          = x_upd;
    y_d          = y_upd;
    cnt_d        = cnt_upd;
    ovf_d        = ovf_upd;
    fg_d         = fg_upd;
    xmin_d       = xmin_upd;
    xmax_d       = xmax_upd;
    ymin_d       = ymin_upd;
    ymax_d       = ymax_upd;
    fg_count_d   = fg_count_q;
    bbox_xmin_d  = bbox_xmin_q;
    bbox_xmax_d  = bbox_xmax_q;
    bbox_ymin_d  = bbox_ymin_q;
    bbox_ymax_d  = bbox_ymax_q;
    bbox_empty_d = bbox_empty_q;
    frame_err_d  = frame_err_q;
    if (frame_done) begin
      fg_count_d   = fg_upd;
      bbox_empty_d = (fg_upd == 10'd0);
      bbox_xmin_d  = (fg_upd == 10'd0) ? 5'd0 : xmin_upd;
      bbox_xmax_d  = (fg_upd == 10'd0) ? 5'd0 : xmax_upd;
      bbox_ymin_d  = (fg_upd == 10'd0) ? 5'd0 : ymin_upd;
      bbox_ymax_d  = (fg_upd == 10'd0) ? 5'd0 : ymax_upd;
      frame_err_d  = (cnt_upd != NumPix) || ovf_upd;
      x_d          = '0;
      y_d          = '0;
      cnt_d        = '0;
      ovf_d        = 1'b0;
      fg_d         = '0;
      xmin_d       = MinInit;
      xmax_d       = '0;
      ymin_d       = MinInit;
      ymax_d       = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_done)        state_d = StReport;
        else if (binary_valid) state_d = StAccum;
      end
      StAccum: begin
        if (frame_done) state_d = StReport;
      end
      StReport: begin
        if (frame_done)        state_d = StReport;
        else if (binary_valid) state_d = StAccum;
        else                   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      fg_q         <= '0;
      xmin_q       <= MinInit;
      xmax_q       <= '0;
      ymin_q       <= MinInit;
      ymax_q       <= '0;
      fg_count_q   <= '0;
      bbox_xmin_q  <= '0;
      bbox_xmax_q  <= '0;
      bbox_ymin_q  <= '0;
      bbox_ymax_q  <= '0;
      bbox_empty_q <= 1'b1;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      fg_q         <= fg_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      fg_count_q   <= fg_count_d;
      bbox_xmin_q  <= bbox_xmin_d;
      bbox_xmax_q  <= bbox_xmax_d;
      bbox_ymin_q  <= bbox_ymin_d;
      bbox_ymax_q  <= bbox_ymax_d;
      bbox_empty_q <= bbox_empty_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef FEAT_CENTROID_EN
  logic [14:0] sx_q, sx_d, sy_q, sy_d;
  logic [14:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;

  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    if (accept && binary_pixel) begin
      sx_d = sx_q + 15'(x_q);
      sy_d = sy_q + 15'(y_q);
    end
    if (frame_done) begin
      sum_x_d = sx_d;
      sum_y_d = sy_d;
      sx_d    = '0;
      sy_d    = '0;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
    end
  end

  assign sum_x = sum_x_q;
  assign sum_y = sum_y_q;
`else
  assign sum_x = '0;
  assign sum_y = '0;
`endif

  assign feat_valid = (state_q == StReport);
  assign fg_count   = fg_count_q;
  assign bbox_xmin  = bbox_xmin_q;
  assign bbox_xmax  = bbox_xmax_q;
  assign bbox_ymin  = bbox_ymin_q;
  assign bbox_ymax  = bbox_ymax_q;
  assign bbox_empty = bbox_empty_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_binary_feature_extractor.sv
// Scoreboard bench for binary_feature_extractor: directed corner frames plus random frames,
// expected features computed from the list of pixels delivered in each frame.
module tb_binary_feature_extractor;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;

  logic        pixel_clk    = 1'b0;
  logic        rst_n        = 1'b0;
  logic        binary_pixel = 1'b0;
  logic        binary_valid = 1'b0;
  logic        frame_done   = 1'b0;
  logic        feat_valid;
  logic [9:0]  fg_count;
  logic [4:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic        bbox_empty;
  logic [14:0] sum_x, sum_y;
  logic        frame_err;

  typedef struct {
    int fg; int xmin; int xmax; int ymin; int ymax; int empty; int sx; int sy; int err;
  } feat_t;

  feat_t sb_q[$];
  bit    cur[$];
  int    n_pass  = 0;
  int    n_total = 0;
  bit    prev_done = 1'b0;

  binary_feature_extractor #(.IMG_W(W), .IMG_H(H)) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .binary_pixel (binary_pixel),
    .binary_valid (binary_valid),
    .frame_done   (frame_done),
    .feat_valid   (feat_valid),
    .fg_count     (fg_count),
    .bbox_xmin    (bbox_xmin),
    .bbox_xmax    (bbox_xmax),
    .bbox_ymin    (bbox_ymin),
    .bbox_ymax    (bbox_ymax),
    .bbox_empty   (bbox_empty),
    .sum_x        (sum_x),
    .sum_y        (sum_y),
    .frame_err    (frame_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: pixel i of the frame sits at (i % W, i / W); pixels past NPIX are dropped.
  function automatic feat_t model();
    feat_t e;
    int n = cur.size();
    int x, y;
    e.fg = 0; e.sx = 0; e.sy = 0;
    e.xmin = 31; e.xmax = 0; e.ymin = 31; e.ymax = 0;
    for (int i = 0; i < n && i < NPIX; i++) begin
      if (cur[i]) begin
        x = i % W;
        y = i / W;
        e.fg++;
        e.sx += x;
        e.sy += y;
        if (x < e.xmin) e.xmin = x;
        if (x > e.xmax) e.xmax = x;
        if (y < e.ymin) e.ymin = y;
        if (y > e.ymax) e.ymax = y;
      end
    end
    e.empty = (e.fg == 0) ? 1 : 0;
    if (e.fg == 0) begin
      e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
    end
    e.err = (n != NPIX) ? 1 : 0;
`ifndef FEAT_CENTROID_EN
    e.sx = 0;
    e.sy = 0;
`endif
    return e;
  endfunction

  task automatic drive(input bit v, input bit p, input bit d);
    binary_valid = v;
    binary_pixel = p;
    frame_done   = d;
    if (v) cur.push_back(p);
    if (d) begin
      sb_q.push_back(model());
      cur.delete();
    end
    @(posedge pixel_clk);
    #1;
    binary_valid = 1'b0;
    binary_pixel = 1'b0;
    frame_done   = 1'b0;
  endtask

  function automatic bit pat(input int kind, input int i, input int dens);
    int x = i % W;
    int y = i / W;
    case (kind)
      1:       return (x >= 3 && x <= 5 && y >= 10 && y <= 20);
      2:       return (i == 0);
      3:       return (i == NPIX - 1);
      4:       return (i >= NPIX);
      default: return (int'($urandom_range(99)) < dens);
    endcase
  endfunction

  // n pixels of pattern kind; frame_done rides with the last pixel when done_last is set.
  task automatic send_frame(input int n, input int kind, input int dens, input bit done_last,
                            input int gap);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < gap) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, pat(kind, i, dens), (done_last && i == n - 1));
    end
    if (!done_last || n == 0) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_feat_valid"}, int'(feat_valid), 0);
    chk({tag, "_fg_count"}, int'(fg_count), 0);
    chk({tag, "_bbox_empty"}, int'(bbox_empty), 1);
    chk({tag, "_bbox"}, int'({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 0);
    chk({tag, "_sums"}, int'({sum_x, sum_y}), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Monitor: feat_valid must follow a sampled frame_done by exactly one cycle.
  always @(negedge pixel_clk) begin
    feat_t e;
    if (rst_n) begin
      if (feat_valid || prev_done) chk("feat_valid_timing", int'(feat_valid), int'(prev_done));
      if (feat_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_feat_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("fg_count", int'(fg_count), e.fg);
          chk("bbox_xmin", int'(bbox_xmin), e.xmin);
          chk("bbox_xmax", int'(bbox_xmax), e.xmax);
          chk("bbox_ymin", int'(bbox_ymin), e.ymin);
          chk("bbox_ymax", int'(bbox_ymax), e.ymax);
          chk("bbox_empty", int'(bbox_empty), e.empty);
          chk("sum_x", int'(sum_x), e.sx);
          chk("sum_y", int'(sum_y), e.sy);
          chk("frame_err", int'(frame_err), e.err);
        end
      end
      prev_done = frame_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    int mode, n, dens;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    send_frame(NPIX, 1, 0, 1'b0, 0);          // box at x=3..5, y=10..20
    drive(1'b0, 1'b0, 1'b0);
    send_frame(NPIX, 0, 0, 1'b0, 0);          // all-zero frame
    drive(1'b0, 1'b0, 1'b0);
    send_frame(NPIX, 3, 0, 1'b1, 0);          // last pixel with frame_done
    drive(1'b0, 1'b0, 1'b0);
    send_frame(NPIX + 16, 4, 0, 1'b0, 0);     // overflow, extras all 1
    send_frame(NPIX, 2, 0, 1'b0, 0);          // first pixel lands during REPORT
    drive(1'b0, 1'b0, 1'b1);                  // frame_done during REPORT: empty frame
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) drive(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    cur.delete();
    #1;
    check_reset_outputs("midreset");
    @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    send_frame(NPIX, 2, 0, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 14; f++) begin
      mode = int'($urandom_range(4));
      dens = int'($urandom_range(50));
      case (mode)
        0:       send_frame(NPIX, 0, dens, 1'b0, 5);
        1:       send_frame(NPIX, 0, dens, 1'b1, 5);
        2:       send_frame(NPIX + int'($urandom_range(1, 10)), 0, dens, 1'b0, 0);
        3:       begin
          n = int'($urandom_range(1, NPIX - 1));
          send_frame(n, 0, dens, 1'b0, 5);
        end
        default: send_frame(0, 0, dens, 1'b0, 0);
      endcase
      if ($urandom_range(1) == 1) drive(1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) drive(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
